// File: rtl/dff_ctrl_pkg.sv
// Shared types and helpers for the shared-DFF access controller.
// Holds the controller state encoding and the round-robin pick function.
// The ID width is derived inside each module from its own NUM_REQ.
package dff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Upper bound on requesters the pick function can search.
    localparam int MAX_REQ = 64;

    // Round-robin search: first set bit of valid at or above ptr, wrapping
    // modulo num_req. Returns the found bit; the winner index goes to idx.
    function automatic logic rr_pick(
        input  logic [MAX_REQ-1:0] valid,
        input  int                 num_req,
        input  int                 ptr,
        output int                 idx
    );
        logic found;
        int   k;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < num_req && !found) begin
                k = ptr + i;
                if (k >= num_req) begin
                    k = k - num_req;
                end
                if (valid[k[5:0]]) begin
                    found = 1'b1;
                    idx   = k;
                end
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/dff_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from req_valid, rotating pointer.
// Latency: grant is combinational; pointer updates on the accepting edge.
// Backpressure: grants only while enable is high; a granted requester holds valid, so grant == accept.
// Ports: clk, reset (async, active-high), req_valid, enable (controller idle),
//        grant (one-hot), grant_idx (winner index), grant_found (a grant is issued this cycle).
module dff_rr_arbiter
    import dff_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_found
);

    logic [ID_W-1:0] ptr;
    logic            pick_found;
    int              pick_idx;

    always_comb begin
        pick_idx    = 0;
        pick_found  = rr_pick(MAX_REQ'(req_valid), NUM_REQ, int'(ptr), pick_idx);
        grant_idx   = ID_W'(pick_idx);
        grant_found = enable && pick_found;
        grant       = '0;
        if (grant_found) begin
            grant = NUM_REQ'(1) << grant_idx;
        end
    end

    // Pointer moves past the winner on every accept; NUM_REQ need not be a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_found) begin
            if (grant_idx == ID_W'(NUM_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dff_access_ctrl.sv
// Shares one DFF between NUM_REQ writers: arbitrate, drive, read back, respond with a mismatch flag.
// Latency: accept in cycle T, rsp_valid in cycle T+3; one transaction per 4 cycles.
// Backpressure: req_ready only in IDLE (never during reset); the response has no backpressure.
// Ports: clk, reset (async, active-high); req_valid/req_data/req_ready per requester;
//        dff_din/dff_dout to the DFF; rsp_valid/rsp_id/rsp_data/rsp_mismatch response;
//        err_cnt saturating mismatch count; busy when not idle.
module dff_access_ctrl
    import dff_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 1,
    parameter int ERR_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           dff_din,
    input  logic [DATA_W-1:0]           dff_dout,
    output logic                        rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_mismatch,
    output logic [ERR_W-1:0]            err_cnt,
    output logic                        busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t              state;
    state_t              state_nxt;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                accept;
    logic [DATA_W-1:0]   win_data;
    logic [DATA_W-1:0]   data_q;
    logic [ID_W-1:0]     id_q;
    logic                mismatch;

    dff_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .enable      (state == IDLE),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_found (accept)
    );

    // State is already IDLE during reset, so the grant must be masked explicitly.
    assign req_ready = grant & {NUM_REQ{~reset}};
    assign win_data  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
    assign mismatch  = (dff_dout != data_q);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DRIVE;
            DRIVE:   state_nxt = SAMPLE;
            SAMPLE:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dff_din      <= '0;
            data_q       <= '0;
            id_q         <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            rsp_mismatch <= 1'b0;
            err_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dff_din <= win_data;
                        data_q  <= win_data;
                        id_q    <= grant_idx;
                    end
                end
                SAMPLE: begin
                    // The DFF captured dff_din at the end of DRIVE, so dff_dout is valid now.
                    rsp_valid    <= 1'b1;
                    rsp_id       <= id_q;
                    rsp_data     <= dff_dout;
                    rsp_mismatch <= mismatch;
                    if (mismatch && (err_cnt != {ERR_W{1'b1}})) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dff_access_ctrl.sv
// Self-checking bench for dff_access_ctrl with a behavioural DFF that can be stuck at zero.
// Latency: checks the T / T+1 / T+3 timing of accept, drive and response.
// Backpressure: checks that ready stays low outside IDLE and during reset.
module tb_dff_access_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [3:0] req_data;
    logic [3:0] req_ready;
    logic [0:0] dff_din;
    logic [0:0] dff_dout;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic [0:0] rsp_data;
    logic       rsp_mismatch;
    logic [7:0] err_cnt;
    logic       busy;

    logic       force_zero = 1'b0;
    logic [0:0] dff_q = 1'b0;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    // Behavioural DFF owned by the controller.
    always @(posedge clk) dff_q <= force_zero ? 1'b0 : dff_din;
    assign dff_dout = dff_q;

    dff_access_ctrl #(
        .NUM_REQ (4),
        .DATA_W  (1),
        .ERR_W   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .dff_din      (dff_din),
        .dff_dout     (dff_dout),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_mismatch (rsp_mismatch),
        .err_cnt      (err_cnt),
        .busy         (busy)
    );

    typedef struct {
        logic [3:0] valid;
        logic [3:0] data;
        logic [3:0] exp_ready;
        logic [1:0] exp_id;
        logic       exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits at negedges for rsp_valid; returns at the negedge where it is seen.
    task automatic wait_rsp(output logic got);
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       got;
        logic [3:0] one;
        one = 4'b0001;

        // valid, data, exp_ready, exp_id, exp_rdata (pointer carried across rows)
        vecs[0] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1}; // single request, ptr 0 -> 3
        vecs[1] = '{4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0}; // top requester, ptr -> 0
        vecs[2] = '{4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1}; // wrap: 0 beats 3, ptr -> 1
        vecs[3] = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1}; // ptr 1 skips to 3, ptr -> 0
        vecs[4] = '{4'b0110, 4'b0010, 4'b0010, 2'd1, 1'b1}; // ptr 0 -> 1 wins, ptr -> 2
        vecs[5] = '{4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0}; // ptr 2 wraps to 0, ptr -> 1
        vecs[6] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}; // no request
        vecs[7] = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1}; // ptr 1 -> 1, ptr -> 2

        // Reset state, with requests pending that must not be granted.
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_data  = 4'b1111;
        step();
        step();
        @(negedge clk);
        check("rst_ready", req_ready, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_dff_din", dff_din, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, 2'd0);
        check("rst_rsp_data", rsp_data, 1'b0);
        check("rst_rsp_mismatch", rsp_mismatch, 1'b0);
        check("rst_err_cnt", err_cnt, 8'd0);
        step();
        reset     = 1'b0;
        req_valid = 4'b0000;
        req_data  = 4'b0000;

        // Reset pulsed during DRIVE aborts the transaction.
        req_valid = 4'b0010;
        req_data  = 4'b0010;
        @(negedge clk);
        check("abort_ready", req_ready, 4'b0010);
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        check("abort_drive_busy", busy, 1'b1);
        check("abort_drive_din", dff_din, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_din", dff_din, 1'b0);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid, 1'b0);
            check("abort_idle", busy, 1'b0);
            step();
        end

        // Table-driven single transactions.
        for (int v = 0; v < 8; v++) begin
            req_valid = vecs[v].valid;
            req_data  = vecs[v].data;
            @(negedge clk);
            check($sformatf("v%0d_ready", v), req_ready, vecs[v].exp_ready);
            check($sformatf("v%0d_idle", v), busy, 1'b0);
            step();
            if (vecs[v].exp_ready == 4'b0000) begin
                req_valid = 4'b0000;
                @(negedge clk);
                check($sformatf("v%0d_stay_idle", v), busy, 1'b0);
                step();
            end else begin
                // Losers keep requesting; nothing may be granted while busy.
                req_valid = vecs[v].valid & ~vecs[v].exp_ready;
                @(negedge clk);
                check($sformatf("v%0d_drive_ready", v), req_ready, 4'b0000);
                check($sformatf("v%0d_dff_din", v), dff_din, vecs[v].exp_rdata);
                check($sformatf("v%0d_drive_rsp", v), rsp_valid, 1'b0);
                step();
                @(negedge clk);
                check($sformatf("v%0d_sample_ready", v), req_ready, 4'b0000);
                check($sformatf("v%0d_sample_rsp", v), rsp_valid, 1'b0);
                step();
                @(negedge clk);
                check($sformatf("v%0d_resp_ready", v), req_ready, 4'b0000);
                check($sformatf("v%0d_rsp_valid", v), rsp_valid, 1'b1);
                check($sformatf("v%0d_rsp_id", v), rsp_id, vecs[v].exp_id);
                check($sformatf("v%0d_rsp_data", v), rsp_data, vecs[v].exp_rdata);
                check($sformatf("v%0d_rsp_mismatch", v), rsp_mismatch, 1'b0);
                check($sformatf("v%0d_err_cnt", v), err_cnt, 8'd0);
                step();
                req_valid = 4'b0000;
                @(negedge clk);
                check($sformatf("v%0d_rsp_drop", v), rsp_valid, 1'b0);
                check($sformatf("v%0d_rsp_id_hold", v), rsp_id, vecs[v].exp_id);
                check($sformatf("v%0d_rsp_data_hold", v), rsp_data, vecs[v].exp_rdata);
                step();
            end
        end

        // Request raised during RESP is ignored until IDLE (ptr is 2 here).
        req_valid = 4'b1000;
        req_data  = 4'b0000;
        @(negedge clk);
        check("busy_first_ready", req_ready, 4'b1000);
        step();
        req_valid = 4'b0000;
        step();
        step();
        req_valid = 4'b0010;
        req_data  = 4'b0010;
        @(negedge clk);
        check("busy_resp_rsp_valid", rsp_valid, 1'b1);
        check("busy_resp_ready", req_ready, 4'b0000);
        step();
        @(negedge clk);
        check("busy_idle_ready", req_ready, 4'b0010);
        step();
        req_valid = 4'b0000;
        wait_rsp(got);
        check("busy_rsp_seen", got, 1'b1);
        check("busy_rsp_id", rsp_id, 2'd1);
        check("busy_rsp_data", rsp_data, 1'b1);
        step();

        // Full contention from ptr 0: grants 0,1,2,3,0 every 4 cycles.
        reset = 1'b1;
        step();
        reset     = 1'b0;
        req_valid = 4'b1111;
        req_data  = 4'b1010;
        for (int cyc = 0; cyc < 20; cyc++) begin
            int phase;
            int slot;
            phase = cyc % 4;
            slot  = (cyc / 4) % 4;
            @(negedge clk);
            check($sformatf("cont_c%0d_ready", cyc), req_ready,
                  (phase == 0) ? (one << slot) : 4'b0000);
            check($sformatf("cont_c%0d_rsp_valid", cyc), rsp_valid, (phase == 3) ? 1'b1 : 1'b0);
            if (phase == 3) begin
                check($sformatf("cont_c%0d_rsp_id", cyc), rsp_id, slot);
                check($sformatf("cont_c%0d_rsp_data", cyc), rsp_data, slot % 2);
                check($sformatf("cont_c%0d_mismatch", cyc), rsp_mismatch, 1'b0);
            end
            step();
        end
        req_valid = 4'b0000;
        step();

        // Stuck-at-zero DFF: every write of 1 mismatches; counter saturates at 255.
        force_zero = 1'b1;
        req_valid  = 4'b0010;
        req_data   = 4'b0010;
        for (int n = 1; n <= 260; n++) begin
            wait_rsp(got);
            check($sformatf("sat_n%0d_rsp_seen", n), got, 1'b1);
            check($sformatf("sat_n%0d_mismatch", n), rsp_mismatch, 1'b1);
            check($sformatf("sat_n%0d_rsp_data", n), rsp_data, 1'b0);
            check($sformatf("sat_n%0d_err_cnt", n), err_cnt, (n > 255) ? 255 : n);
            step();
        end
        req_valid = 4'b0000;
        step();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/dff_access_ctrl.md
Name: dff_access_ctrl

Overview:
- Controller that shares the single `dff` storage element between NUM_REQ requesters.
- Arbitrates write requests round-robin, drives the winning data onto the DFF input, reads the DFF output back after capture, and returns a tagged response with a mismatch flag.
- Sits between requester agents and the `dff` instance, which it owns exclusively; it is the only driver of the DFF data input.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 1, width of the DFF datapath.
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_data  in  NUM_REQ*DATA_W  per-requester write data; slice i belongs to requester i.
- req_ready  out  NUM_REQ  one-hot grant; combinational.
- dff_din  out  DATA_W  registered drive to the DFF data input.
- dff_dout  in  DATA_W  DFF output.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester being answered.
- rsp_data  out  DATA_W  value read back from the DFF.
- rsp_mismatch  out  1  rsp_data differs from the written data.
- err_cnt  out  ERR_W  saturating count of mismatches.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high), all outputs and state cleared:
  - state=IDLE, ptr=0, dff_din=0, data_q=0, id_q=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_mismatch=0, err_cnt=0.
- Reset asserted mid-transaction aborts it: no response is issued and no grant is given while reset is high.
- FSM: IDLE -> DRIVE -> SAMPLE -> RESP -> IDLE.
- IDLE:
  - Winner g is the first valid requester searching upward from ptr, wrapping modulo NUM_REQ.
  - req_ready[g]=1; all other ready bits 0. If no request is valid, all ready=0.
  - Accept at the edge where req_valid[g] && req_ready[g]: dff_din<=req_data[g], data_q<=req_data[g], id_q<=g, ptr<=(g+1) mod NUM_REQ, go to DRIVE.
- DRIVE: the DFF captures dff_din at the end of this cycle. No grants. Go to SAMPLE.
- SAMPLE: at the edge:
  - rsp_data<=dff_dout, rsp_id<=id_q, rsp_valid<=1.
  - rsp_mismatch<=(dff_dout!=data_q).
  - If mismatch, err_cnt<=err_cnt+1, saturating at 2^ERR_W-1 with no wrap.
  - Go to RESP.
- RESP:
  - rsp_valid is high for exactly this one cycle; there is no backpressure on the response.
  - No grants. rsp_valid<=0 at the edge, go to IDLE.
  - rsp_id, rsp_data and rsp_mismatch hold until the next response.
- Latency and throughput: accept in cycle T, rsp_valid high in cycle T+3. At most one transaction every 4 cycles.
- dff_din holds its value between transactions.
- Requester rule: req_valid and req_data must stay stable until ready. The controller ignores valid outside IDLE.
- Simultaneous requests are resolved only by round-robin; there is no fixed priority beyond the ptr ordering.
- The pointer advances only on accept. ptr=NUM_REQ-1 followed by a grant wraps to 0.

Decomposition:
- Package dff_ctrl_pkg, holding:
  - state_t enum {IDLE, DRIVE, SAMPLE, RESP};
  - function rr_pick(valid, ptr) returning the index and a found bit;
  - constant ID_W = $clog2(NUM_REQ) computed locally from the parameter.
- Sub-module dff_rr_arbiter:
  - combinational one-hot grant from req_valid and ptr, plus the registered ptr update on accept;
  - dff_access_ctrl instantiates it and holds the FSM, the data/ID registers and the error counter.

Test Plan:
- Reset mid-DRIVE: requester 1 accepted with data 1, reset pulsed in DRIVE -> rsp_valid never rises, all outputs 0, state IDLE; next request is granted normally.
- Single request: req_valid[2]=1, req_data[2]=1 in cycle 0 -> req_ready=4'b0100 in cycle 0, dff_din=1 from cycle 1, rsp_valid in cycle 3 with rsp_id=2, rsp_data=1, rsp_mismatch=0, err_cnt=0.
- Full contention: all four valid continuously, data_i=i[0] -> grant order 0,1,2,3,0 at cycles 0,4,8,12,16; rsp_data sequence 0,1,0,1,0.
- Wrap-around: grant requester 3 first, then requesters 0 and 3 both valid -> requester 0 granted next and ptr=1.
- Fault/saturation: bench forces dff_dout=0 and writes 1 repeatedly -> rsp_mismatch=1 on each response, err_cnt counts 1,2,... and stays at 255 after 260 transactions.
- Ignore while busy: req_valid[1] raised in the RESP cycle -> req_ready=0 that cycle; granted in the following IDLE cycle.
